// File: rtl/video_timing_pkg.sv
// Shared raster definitions: standard CEA timing sets and the line/frame total helper.
package video_timing_pkg;

  localparam int CNT_W = 12;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } axis_t;

  typedef struct packed {
    axis_t h;
    axis_t v;
    bit    hs_pol;
    bit    vs_pol;
  } mode_t;

  localparam mode_t MODE_480P  = '{h: '{640, 16, 96, 48},    v: '{480, 10, 2, 33}, hs_pol: 1'b0, vs_pol: 1'b0};
  localparam mode_t MODE_720P  = '{h: '{1280, 110, 40, 220}, v: '{720, 5, 5, 20},  hs_pol: 1'b1, vs_pol: 1'b1};
  localparam mode_t MODE_1080P = '{h: '{1920, 88, 44, 148},  v: '{1080, 4, 5, 36}, hs_pol: 1'b1, vs_pol: 1'b1};

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/timing_counter.sv
// Wrap counter 0..COUNT-1 advancing when en_i is high; tc_o flags the last count.
// Zero-latency terminal count, no backpressure.
module timing_counter
  import video_timing_pkg::*;
#(
  parameter int COUNT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  if (COUNT < 1 || COUNT > (1 << CNT_W)) begin : g_count_chk
    $error("timing_counter: COUNT out of range for counter width");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == LAST);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source: hs/vs/de/x/y/frame_start registered one stage from the h/v counters.
// One-cycle latency from counter sample, free-running with no backpressure.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = MODE_1080P.h.active,
  parameter int H_FP     = MODE_1080P.h.fp,
  parameter int H_SYNC   = MODE_1080P.h.sync,
  parameter int H_BP     = MODE_1080P.h.bp,
  parameter int V_ACTIVE = MODE_1080P.v.active,
  parameter int V_FP     = MODE_1080P.v.fp,
  parameter int V_SYNC   = MODE_1080P.v.sync,
  parameter int V_BP     = MODE_1080P.v.bp,
  parameter bit HS_POL   = MODE_1080P.hs_pol,
  parameter bit VS_POL   = MODE_1080P.vs_pol
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] hactive,
  output logic [15:0] vactive,
  output logic        timing_hs,
  output logic        timing_vs,
  output logic        timing_de,
  output logic [11:0] timing_x,
  output logic [11:0] timing_y,
  output logic        frame_start
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_total_chk
    $error("video_timing_gen: H_TOTAL and V_TOTAL must fit the 12-bit counters");
  end

  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_tc;

  timing_counter #(.COUNT(H_TOTAL)) u_h_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (1'b1),
    .cnt_o (h_cnt),
    .tc_o  (h_tc)
  );

  // Vertical advances on the same edge the line wraps, so vs flips at h_cnt==0.
  timing_counter #(.COUNT(V_TOTAL)) u_v_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (h_tc),
    .cnt_o (v_cnt),
    .tc_o  ()
  );

  logic             hs_d, vs_d, de_d, fs_d;
  logic [CNT_W-1:0] x_d, y_d;
  logic             hs_q, vs_q, de_q, fs_q;
  logic [CNT_W-1:0] x_q, y_q;

  assign de_d = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign hs_d = ((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END)) ? HS_POL : ~HS_POL;
  assign vs_d = ((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END)) ? VS_POL : ~VS_POL;
  assign x_d  = de_d ? h_cnt : '0;
  assign y_d  = de_d ? v_cnt : '0;
  assign fs_d = (h_cnt == '0) && (v_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      de_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
      fs_q <= 1'b0;
    end else begin
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      x_q  <= x_d;
      y_q  <= y_d;
      fs_q <= fs_d;
    end
  end

  assign hactive     = 16'(H_ACTIVE);
  assign vactive     = 16'(V_ACTIVE);
  assign timing_hs   = hs_q;
  assign timing_vs   = vs_q;
  assign timing_de   = de_q;
  assign timing_x    = x_q;
  assign timing_y    = y_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench: small raster in both sync polarities against a scoreboard, plus a 1080p line check.
module tb_video_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
  } obs_t;

  typedef struct {
    logic rst;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] a_hact, a_vact, b_hact, b_vact, c_hact, c_vact;
  logic        a_hs, a_vs, a_de, a_fs, b_hs, b_vs, b_de, b_fs, c_hs, c_vs, c_de, c_fs;
  logic [11:0] a_x, a_y, b_x, b_y, c_x, c_y;

  video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                     .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .hactive(a_hact), .vactive(a_vact), .timing_hs(a_hs),
    .timing_vs(a_vs), .timing_de(a_de), .timing_x(a_x), .timing_y(a_y), .frame_start(a_fs));

  video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                     .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .hactive(b_hact), .vactive(b_vact), .timing_hs(b_hs),
    .timing_vs(b_vs), .timing_de(b_de), .timing_x(b_x), .timing_y(b_y), .frame_start(b_fs));

  video_timing_gen u_c (
    .clk(clk), .rst_n(rst_n), .hactive(c_hact), .vactive(c_vact), .timing_hs(c_hs),
    .timing_vs(c_vs), .timing_de(c_de), .timing_x(c_x), .timing_y(c_y), .frame_start(c_fs));

  obs_t a_obs, b_obs;
  assign a_obs = {a_hs, a_vs, a_de, a_x, a_y, a_fs};
  assign b_obs = {b_hs, b_vs, b_de, b_x, b_y, b_fs};

  int   checks = 0;
  int   fails = 0;
  int   s = 0;
  int   cyc = 0;
  obs_t qa[$], qb[$];

  // Small-raster statistics (A), gated over a two-frame window.
  bit   stat_en = 0;
  int   hs_hi = 0, vs_hi = 0, de_hi = 0, fs_n = 0, fs_gap = 0, fs_last = -1, vs_off = 0;
  logic prev_vs = 1'b0;
  // 1080p statistics (C).
  bit   c_en = 0;
  int   c_de_n = 0, c_hs_n = 0, c_period = 0, c_rise = -1, c_xmax = 0;
  logic c_prev_de = 1'b0;

  function automatic obs_t model(input int smp, input bit pol);
    obs_t o;
    int   hp, ln;
    hp   = smp % 15;
    ln   = (smp / 15) % 8;
    o.de = (hp < 8) && (ln < 4);
    o.x  = o.de ? 12'(hp) : 12'd0;
    o.y  = o.de ? 12'(ln) : 12'd0;
    o.hs = (hp >= 10 && hp < 13) ? pol : ~pol;
    o.vs = (ln >= 5 && ln < 7) ? pol : ~pol;
    o.fs = (smp % 120) == 0;
    return o;
  endfunction

  function automatic obs_t idle(input bit pol);
    obs_t o;
    o    = '0;
    o.hs = ~pol;
    o.vs = ~pol;
    return o;
  endfunction

  function automatic vec_t mk(input logic r, input logic hs, input logic vs, input logic de,
                              input int x, input int y, input logic fs);
    vec_t v;
    v.rst = r;
    v.exp = {hs, vs, de, 12'(x), 12'(y), fs};
    return v;
  endfunction

  task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got hs%b vs%b de%b x%0d y%0d fs%b, want hs%b vs%b de%b x%0d y%0d fs%b",
               name, cyc, act.hs, act.vs, act.de, act.x, act.y, act.fs,
               exp.hs, exp.vs, exp.de, exp.x, exp.y, exp.fs);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Drive one edge: push the expected sample, clock, then pop and compare.
  task automatic cycle(input logic r);
    obs_t ea, eb;
    int   idx;
    rst_n = r;
    idx   = s;
    if (!r) begin
      qa.push_back(idle(1'b1));
      qb.push_back(idle(1'b0));
      s = 0;
    end else begin
      qa.push_back(model(s, 1'b1));
      qb.push_back(model(s, 1'b0));
      s++;
    end
    @(posedge clk);
    #1;
    ea = qa.pop_front();
    eb = qb.pop_front();
    chk_obs("sb_pos", a_obs, ea);
    chk_obs("sb_neg", b_obs, eb);
    if (stat_en) begin
      hs_hi += int'(a_hs);
      vs_hi += int'(a_vs);
      de_hi += int'(a_de);
      if (a_vs != prev_vs && (idx % 15) != 0) vs_off++;
      if (a_fs) begin
        fs_n++;
        if (fs_last >= 0) fs_gap = cyc - fs_last;
        fs_last = cyc;
      end
    end
    prev_vs = a_vs;
    if (c_en) begin
      c_de_n += int'(c_de);
      c_hs_n += int'(c_hs);
      if (c_de && int'(c_x) > c_xmax) c_xmax = int'(c_x);
      if (c_de && !c_prev_de) begin
        if (c_rise >= 0) c_period = cyc - c_rise;
        c_rise = cyc;
      end
    end
    c_prev_de = c_de;
    cyc++;
  endtask

  vec_t tv[13];

  initial begin
    bit found;
    tv[0]  = mk(1'b0, 0, 0, 0, 0, 0, 0);
    tv[1]  = mk(1'b0, 0, 0, 0, 0, 0, 0);
    tv[2]  = mk(1'b0, 0, 0, 0, 0, 0, 0);
    tv[3]  = mk(1'b1, 0, 0, 1, 0, 0, 1);
    tv[4]  = mk(1'b1, 0, 0, 1, 1, 0, 0);
    tv[5]  = mk(1'b1, 0, 0, 1, 2, 0, 0);
    tv[6]  = mk(1'b1, 0, 0, 1, 3, 0, 0);
    tv[7]  = mk(1'b1, 0, 0, 1, 4, 0, 0);
    tv[8]  = mk(1'b1, 0, 0, 1, 5, 0, 0);
    tv[9]  = mk(1'b1, 0, 0, 1, 6, 0, 0);
    tv[10] = mk(1'b1, 0, 0, 1, 7, 0, 0);
    tv[11] = mk(1'b1, 0, 0, 0, 0, 0, 0);
    tv[12] = mk(1'b1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      cycle(tv[i].rst);
      chk_obs("vec_release", a_obs, tv[i].exp);
    end

    chk_int("a_hactive", int'(a_hact), 8);
    chk_int("a_vactive", int'(a_vact), 4);
    chk_int("c_hactive", int'(c_hact), 1920);
    chk_int("c_vactive", int'(c_vact), 1080);

    while (s < 120) cycle(1'b1);
    stat_en = 1;
    repeat (240) cycle(1'b1);
    stat_en = 0;
    chk_int("hs_clocks_2frames", hs_hi, 48);
    chk_int("vs_clocks_2frames", vs_hi, 60);
    chk_int("de_clocks_2frames", de_hi, 64);
    chk_int("fs_pulses", fs_n, 2);
    chk_int("fs_period", fs_gap, 120);
    chk_int("vs_edge_off_line_start", vs_off, 0);

    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      cycle(1'b1);
      found = a_de && a_x == 12'd5 && a_y == 12'd2;
    end
    chk_int("reach_x5_y2", int'(found), 1);
    cycle(1'b0);
    chk_obs("midframe_reset_pos", a_obs, tv[0].exp);
    chk_obs("midframe_reset_neg", b_obs, idle(1'b0));
    c_en = 1;
    cycle(1'b1);
    chk_obs("rerelease", a_obs, tv[3].exp);
    repeat (4399) cycle(1'b1);
    c_en = 0;
    chk_int("c_de_2lines", c_de_n, 3840);
    chk_int("c_hs_2lines", c_hs_n, 88);
    chk_int("c_line_period", c_period, 2200);
    chk_int("c_x_max", c_xmax, 1919);
    chk_int("c_hactive_after_reset", int'(c_hact), 1920);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing source that drives the test-pattern stages of the HDMI output chain.
- Free-running horizontal and vertical counters produce registered hs, vs, de and active-area x/y coordinates, all cycle-aligned.
- Also outputs the static active width/height and a start-of-frame pulse.
- Pattern generators consume these outputs directly with one register stage of their own.

Parameters:
H_ACTIVE, 1920, active pixels per line
H_FP, 88, horizontal front porch (clocks)
H_SYNC, 44, horizontal sync width (clocks)
H_BP, 148, horizontal back porch (clocks)
V_ACTIVE, 1080, active lines per frame
V_FP, 4, vertical front porch (lines)
V_SYNC, 5, vertical sync width (lines)
V_BP, 36, vertical back porch (lines)
HS_POL, 1, hs level while in sync (1 = active-high)
VS_POL, 1, vs level while in sync

Ports:
clk  in  1  pixel clock
rst_n  in  1  synchronous reset, active-low
hactive  out  16  constant H_ACTIVE
vactive  out  16  constant V_ACTIVE
timing_hs  out  1  horizontal sync, polarity HS_POL
timing_vs  out  1  vertical sync, polarity VS_POL
timing_de  out  1  data enable, high in active area
timing_x  out  12  active pixel column, 0..H_ACTIVE-1
timing_y  out  12  active line, 0..V_ACTIVE-1
frame_start  out  1  one-clock pulse on first active pixel of frame

Behaviour:
- Reset and clocking
  - One clock. Reset is synchronous and active-low: sampled only on the rising clk edge while rst_n=0.
- Totals
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Counters (internal, 12 bit)
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments only when h_cnt==H_TOTAL-1; wraps 0 after V_TOTAL-1 (same edge h_cnt wraps).
- Line layout (h_cnt)
  - active [0,H_ACTIVE)
  - FP [H_ACTIVE, H_ACTIVE+H_FP)
  - sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - BP to end of line.
- Frame layout (v_cnt) follows the same order with V_* values. Vertical sync spans whole lines, changing state when h_cnt=0.
- Decode, registered one stage from the current counter values:
  - de = h_active AND v_active.
  - hs = HS_POL in h sync region, else ~HS_POL.
  - vs = VS_POL in v sync region, else ~VS_POL.
  - x = h_cnt and y = v_cnt when de; otherwise x and y hold 0.
  - frame_start = (h_cnt==0 AND v_cnt==0).
- Alignment: all of hs, vs, de, x, y and frame_start describe the same counter sample. Zero skew between them.
- Reset values (registered outputs and counters)
  - h_cnt=0, v_cnt=0, de=0, x=0, y=0, frame_start=0.
  - hs=~HS_POL, vs=~VS_POL.
- Latency after reset
  - On the first edge with rst_n=1, outputs register h_cnt=0/v_cnt=0: de=1, x=0, y=0, frame_start=1.
  - On that same edge h_cnt advances to 1.
- Reset mid-frame: on the next edge, counters and outputs return to reset values; no partial-line completion.
- hactive and vactive are constant zero-extended parameter values and are unaffected by reset.
- Width rule: x and y are 12 bit; H_TOTAL and V_TOTAL must be ≤4096 (elaboration-time check).

Decomposition:
- Package video_timing_pkg holds:
  - timing parameter sets for 480p, 720p and 1080p as localparam constants
  - a derived-total helper function.
- Natural sub-module: timing_counter (parameterised wrap counter with terminal-count output), instantiated twice.
  - horizontal instance: enable tied high
  - vertical instance: enable = horizontal terminal count
- Sync/de decode and the output register stage stay in the top.

Test Plan:
Small config for all tests except test 6: H 8/2/3/2 (H_TOTAL 15), V 4/1/2/1 (V_TOTAL 8), HS_POL=VS_POL=1.
1. Release rst_n after 3 clocks -> first edge: de=1, x=0, y=0, frame_start=1, hs=0, vs=0. Next 7 edges: x=1..7 with de=1, then de=0 and x=0.
2. Run one line -> hs=1 for exactly 3 clocks at line offsets 10..12. de high 8 clocks per line. Line period 15 clocks.
3. Run full frame -> y steps 0..3 on active lines. vs=1 for exactly 30 clocks (lines 5..6), changing at line start. frame_start period 120 clocks.
4. Assert rst_n=0 for 1 clock at x=5, y=2 -> next edge all outputs at reset values. First edge after release reproduces test 1.
5. Rebuild with HS_POL=0, VS_POL=0 -> idle hs=vs=1, sync regions 0. de, x and y are identical to test 3.
6. 1080p defaults, 2 frames -> 2200 clocks per line, 1125 lines per frame. De count per frame 2,073,600. hactive=1920, vactive=1080.
